sensor_debounce: RTL and testbench

- Conditioning stage directly upstream of `top`. It drives top's `a`/`b` sensor inputs.
- Takes the two raw, asynchronous gate sensor lines (`a_raw`, `b_raw`) and passes each through a synchroniser and then a debounce filter.
- Emits clean levels `a`/`b` plus one-cycle change pulses.
- Keeps a saturating count of rejected glitches for the scoreboard and lab display.
- Both channels are identical and fully independent, except that they share the glitch counter.

---
 rtl/sensor_debounce.sv | 95 +++++++++
 tb/tb_sensor_debounce.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : sensor_debounce
// Brief    : Two-channel synchroniser + debounce filter for raw gate sensors,
//            with edge pulses and a shared saturating glitch counter.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4,
    parameter int GCNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_raw,
    input  logic              b_raw,
    output logic              a,
    output logic              b,
    output logic              a_edge,
    output logic              b_edge,
    output logic [GCNT_W-1:0] glitch_count
);

    localparam int                c_CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DB_CYCLES - 1);
    localparam logic [GCNT_W-1:0]  c_GMAX  = {GCNT_W{1'b1}};

    logic [1:0] w_raw;
    logic [1:0] w_stable;
    logic [1:0] w_edge;
    logic [1:0] w_glitch;

    assign w_raw = {b_raw, a_raw};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic [c_CNT_W-1:0]     r_cnt;
        logic                   r_stable;
        logic                   r_edge;
        logic                   w_s;

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_sync   <= '0;
                r_cnt    <= '0;
                r_stable <= 1'b0;
                r_edge   <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[g]};
                r_edge <= 1'b0;
                if (w_s == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_LAST) begin
                    r_stable <= w_s;
                    r_cnt    <= '0;
                    r_edge   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end

        // A candidate that falls back before acceptance leaves a nonzero count behind.
        assign w_glitch[g] = (w_s == r_stable) && (r_cnt != '0);
        assign w_stable[g] = r_stable;
        assign w_edge[g]   = r_edge;
    end

    logic [1:0]        w_inc;
    logic [GCNT_W:0]   w_sum;
    logic [GCNT_W-1:0] r_gcnt;

    assign w_inc = {1'b0, w_glitch[0]} + {1'b0, w_glitch[1]};
    assign w_sum = {1'b0, r_gcnt} + (GCNT_W+1)'(w_inc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gcnt <= '0;
        end else if (w_sum[GCNT_W]) begin
            r_gcnt <= c_GMAX;
        end else begin
            r_gcnt <= w_sum[GCNT_W-1:0];
        end
    end

    assign a            = w_stable[0];
    assign b            = w_stable[1];
    assign a_edge       = w_edge[0];
    assign b_edge       = w_edge[1];
    assign glitch_count = r_gcnt;

endmodule
`default_nettype wire

// File: tb/tb_sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_debounce
// Brief    : Directed self-checking bench for sensor_debounce (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_debounce;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_raw;
    logic       b_raw;
    logic       a;
    logic       b;
    logic       a_edge;
    logic       b_edge;
    logic [7:0] glitch_count;

    int n_checks = 0;
    int n_fail   = 0;

    sensor_debounce #(
        .SYNC_STAGES(2),
        .DB_CYCLES  (4),
        .GCNT_W     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_raw       (a_raw),
        .b_raw       (b_raw),
        .a           (a),
        .b           (b),
        .a_edge      (a_edge),
        .b_edge      (b_edge),
        .glitch_count(glitch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int         n_a_edge;
        int         n_b_edge;
        int         n_b_high;
        int         exp_g;
        logic [1:0] hist [1:40];
        logic [1:0] ph;
        logic [1:0] exp_ab;

        // Reset held 3 cycles with raw lines high
        reset = 1'b1;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_outs", int'({a, b, a_edge, b_edge}), 0);
            chk("rst_gcnt", int'(glitch_count), 0);
        end
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 5) chk("post_rst_e5", int'({a, b, a_edge, b_edge}), 0);
            if (e == 6) chk("post_rst_e6", int'({a, b, a_edge, b_edge}), 4'b1111);
            if (e == 7) chk("post_rst_e7", int'({a, b, a_edge, b_edge}), 4'b1100);
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        repeat (10) tick();
        chk("back_idle", int'({a, b}), 0);

        // Clean rise and fall on channel A
        n_a_edge = 0;
        a_raw    = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (a_edge) n_a_edge++;
            if (e == 10) a_raw = 1'b0;
            if (e == 5)  chk("a_rise_e5", int'(a), 0);
            if (e == 6)  chk("a_rise_e6", int'(a), 1);
            if (e == 15) chk("a_fall_e15", int'(a), 1);
            if (e == 16) chk("a_fall_e16", int'(a), 0);
        end
        chk("a_edge_count", n_a_edge, 2);
        chk("a_clean_gcnt", int'(glitch_count), 0);

        // Short pulses on B: 2 and 3 cycles rejected, 4 cycles accepted
        for (int len = 2; len <= 4; len++) begin
            n_b_high = 0;
            n_b_edge = 0;
            b_raw    = 1'b1;
            for (int e = 1; e <= 14; e++) begin
                tick();
                if (e == len) b_raw = 1'b0;
                if (b)      n_b_high++;
                if (b_edge) n_b_edge++;
            end
            chk($sformatf("b_pulse%0d_high", len), n_b_high, (len == 4) ? 4 : 0);
            chk($sformatf("b_pulse%0d_edges", len), n_b_edge, (len == 4) ? 2 : 0);
            chk($sformatf("b_pulse%0d_gcnt", len), int'(glitch_count), (len == 4) ? 2 : len - 1);
        end

        // Car entry: a; a+b; b; none -- outputs follow raw five edges later
        for (int e = 1; e <= 40; e++) begin
            case ((e - 1) / 8)
                0:       ph = 2'b10;
                1:       ph = 2'b11;
                2:       ph = 2'b01;
                default: ph = 2'b00;
            endcase
            hist[e] = ph;
            a_raw   = ph[1];
            b_raw   = ph[0];
            tick();
            exp_ab = (e > 5) ? hist[e-5] : 2'b00;
            chk($sformatf("car_e%0d", e), int'({a, b}), int'(exp_ab));
        end
        repeat (6) tick();
        chk("car_idle", int'({a, b}), 0);
        chk("car_gcnt", int'(glitch_count), 2);

        // Saturation with simultaneous glitches on both channels
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sat_start", int'(glitch_count), 0);
        for (int i = 1; i <= 130; i++) begin
            a_raw = 1'b1;
            b_raw = 1'b1;
            tick();
            tick();
            a_raw = 1'b0;
            b_raw = 1'b0;
            repeat (6) tick();
            exp_g = (2 * i > 255) ? 255 : 2 * i;
            chk($sformatf("sat_step%0d", i), int'(glitch_count), exp_g);
        end
        chk("sat_outs", int'({a, b, a_edge, b_edge}), 0);

        // Reset mid-debounce on A, asserted between clock edges
        a_raw = 1'b1;
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        chk("async_rst_gcnt", int'(glitch_count), 0);
        chk("async_rst_a", int'({a, a_edge}), 0);
        tick();
        tick();
        chk("mid_rst_hold", int'({a, a_edge}), 0);
        reset    = 1'b0;
        n_a_edge = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (a_edge) n_a_edge++;
            if (e == 5) chk("mid_rst_e5", int'(a), 0);
            if (e == 6) chk("mid_rst_e6", int'({a, a_edge}), 2'b11);
        end
        chk("mid_rst_edges", n_a_edge, 1);
        chk("mid_rst_gcnt", int'(glitch_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
